// File: rtl/skein_pkg.sv
// Shared definitions for the Skein UBI tweak datapath.
//   - UBI type codes carried in T1[61:56]
//   - T1 bit positions for the type field and the first/final flags
//   - Sequencer FSM state encoding
//   - Legal Threefish state sizes
// No ports; imported by tweak_pack and tweak_sequencer.
package skein_pkg;

    // UBI block types
    localparam logic [5:0] TYPE_KEY = 6'h00;
    localparam logic [5:0] TYPE_CFG = 6'h04;
    localparam logic [5:0] TYPE_MSG = 6'h30;
    localparam logic [5:0] TYPE_OUT = 6'h3F;

    // T1 field positions
    localparam int TYPE_LSB  = 56;
    localparam int FIRST_BIT = 62;
    localparam int FINAL_BIT = 63;

    // Legal Threefish state sizes in bits
    localparam int SB_256  = 256;
    localparam int SB_512  = 512;
    localparam int SB_1024 = 1024;

    // Sequencer FSM encoding, kept as plain constants for older tools
    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_EMIT = 1'b1;

endpackage

// File: rtl/tweak_pack.sv
// Combinational packing of a UBI block position, type and first/final flags
// into the three 64-bit Threefish tweak words.
//   pos_i   [POS_W-1:0]  byte position reached at the end of this block
//   type_i  [5:0]        UBI type
//   first_i              block is the first of the UBI sequence
//   final_i              block is the last of the UBI sequence
//   t0_o    [63:0]       T0 = pos[63:0]
//   t1_o    [63:0]       T1 = {final, first, type, 24'b0, pos[95:64]}
//   t2_o    [63:0]       T0 ^ T1 when TWEAK_T2_EN is defined, otherwise 0
// Configuration macro: TWEAK_T2_EN.
// POS_W must not exceed 96.
module tweak_pack
    import skein_pkg::*;
#(
    parameter int POS_W = 96
) (
    input  logic [POS_W-1:0] pos_i,
    input  logic [5:0]       type_i,
    input  logic             first_i,
    input  logic             final_i,
    output logic [63:0]      t0_o,
    output logic [63:0]      t1_o,
    output logic [63:0]      t2_o
);

    // Position zero-extended to the full 96-bit UBI position field. Done
    // bit by bit so no zero-width replication appears when POS_W == 96.
    logic [95:0] pos_ext;

    genvar gi;
    generate
        for (gi = 0; gi < 96; gi++) begin : g_ext
            if (gi < POS_W) begin : g_bit
                assign pos_ext[gi] = pos_i[gi];
            end else begin : g_zero
                assign pos_ext[gi] = 1'b0;
            end
        end
    endgenerate

    assign t0_o = pos_ext[63:0];

    // Tree level and bit-pad fields (T1[55:32]) are always zero here.
    always_comb begin
        t1_o                    = 64'h0;
        t1_o[31:0]              = pos_ext[95:64];
        t1_o[TYPE_LSB +: 6]     = type_i;
        t1_o[FIRST_BIT]         = first_i;
        t1_o[FINAL_BIT]         = final_i;
    end

`ifdef TWEAK_T2_EN
    assign t2_o = t0_o ^ t1_o;
`else
    // Key schedule derives T2 itself in this build.
    assign t2_o = 64'h0;
`endif

endmodule

// File: rtl/tweak_sequencer.sv
// Skein UBI tweak sequencer: emits one tweak per state-sized block of a
// message of msg_len_i bytes, over a valid/ready handshake.
//   clk_i          clock
//   rst_n_i        synchronous active-low reset
//   start_i        begin a new sequence (only honoured while idle)
//   type_i [5:0]   UBI type, sampled with an accepted start
//   msg_len_i      message length in bytes, sampled with an accepted start
//   tweak_o [191:0] {T2, T1, T0}; zero while no tweak is valid
//   tweak_valid_o  tweak_o carries a tweak
//   tweak_ready_i  consumer takes the tweak when valid & ready
//   last_o         current tweak is the final block
//   busy_o         sequence in progress
//   done_o         one-cycle pulse after the final tweak is taken
// Configuration macro: TWEAK_T2_EN (selects T2 = T0 ^ T1 inside tweak_pack).
module tweak_sequencer
    import skein_pkg::*;
#(
    parameter int STATE_BITS = SB_512,
    parameter int POS_W      = 96
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [5:0]       type_i,
    input  logic [POS_W-1:0] msg_len_i,
    output logic [191:0]     tweak_o,
    output logic             tweak_valid_o,
    input  logic             tweak_ready_i,
    output logic             last_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int BLOCK_BYTES = STATE_BITS / 8;
    localparam logic [POS_W:0] STEP = (POS_W + 1)'(BLOCK_BYTES);

    state_t           state_q, state_d;
    logic [POS_W-1:0] pos_q,   pos_d;
    logic [POS_W-1:0] len_q,   len_d;
    logic [5:0]       type_q,  type_d;
    logic             first_q, first_d;
    logic             done_q,  done_d;

    logic             final_w;
    logic [63:0]      t0_w, t1_w, t2_w;

    // Next block end position, min(prev + BLOCK_BYTES, len). The sum is one
    // bit wider than the position so it cannot wrap near 2^POS_W.
    function automatic logic [POS_W-1:0] sat_step(input logic [POS_W-1:0] prev,
                                                   input logic [POS_W-1:0] len);
        logic [POS_W:0] sum;
        sum = {1'b0, prev} + STEP;
        return (sum >= {1'b0, len}) ? len : sum[POS_W-1:0];
    endfunction

    assign final_w = (pos_q == len_q);

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        len_d   = len_q;
        type_d  = type_q;
        first_d = first_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_EMIT;
                    type_d  = type_i;
                    len_d   = msg_len_i;
                    pos_d   = sat_step('0, msg_len_i);
                    first_d = 1'b1;
                end
            end
            ST_EMIT: begin
                if (tweak_ready_i) begin
                    if (final_w) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        pos_d   = sat_step(pos_q, len_q);
                        first_d = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            pos_q   <= '0;
            len_q   <= '0;
            type_q  <= '0;
            first_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            len_q   <= len_d;
            type_q  <= type_d;
            first_q <= first_d;
            done_q  <= done_d;
        end
    end

    tweak_pack #(
        .POS_W (POS_W)
    ) u_pack (
        .pos_i   (pos_q),
        .type_i  (type_q),
        .first_i (first_q),
        .final_i (final_w),
        .t0_o    (t0_w),
        .t1_o    (t1_w),
        .t2_o    (t2_w)
    );

    // All tweak outputs come straight from registers, so they hold still
    // for as long as the consumer stalls.
    assign tweak_valid_o = (state_q == ST_EMIT);
    assign busy_o        = tweak_valid_o;
    assign last_o        = tweak_valid_o & final_w;
    assign done_o        = done_q;
    assign tweak_o       = tweak_valid_o ? {t2_w, t1_w, t0_w} : 192'h0;

endmodule

// File: tb/tb_tweak_sequencer.sv
module tb_tweak_sequencer;
    import skein_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: STATE_BITS=512, POS_W=96
    logic         rst_n;
    logic         start;
    logic [5:0]   typ;
    logic [95:0]  len;
    logic         ready;
    logic [191:0] tweak;
    logic         valid, last, busy, done;

    // Narrow instance: POS_W=8, exercises saturation next to 2^POS_W
    logic         s_start;
    logic [5:0]   s_typ;
    logic [7:0]   s_len;
    logic         s_ready;
    logic [191:0] s_tweak;
    logic         s_valid, s_last, s_busy, s_done;

    int total = 0;
    int bad   = 0;

    tweak_sequencer #(.STATE_BITS(512), .POS_W(96)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .start_i       (start),
        .type_i        (typ),
        .msg_len_i     (len),
        .tweak_o       (tweak),
        .tweak_valid_o (valid),
        .tweak_ready_i (ready),
        .last_o        (last),
        .busy_o        (busy),
        .done_o        (done)
    );

    tweak_sequencer #(.STATE_BITS(512), .POS_W(8)) dut_s (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .start_i       (s_start),
        .type_i        (s_typ),
        .msg_len_i     (s_len),
        .tweak_o       (s_tweak),
        .tweak_valid_o (s_valid),
        .tweak_ready_i (s_ready),
        .last_o        (s_last),
        .busy_o        (s_busy),
        .done_o        (s_done)
    );

    typedef struct {
        logic        is_start;
        logic [5:0]  typ;
        logic [95:0] len;
        logic [63:0] t0;
        logic [63:0] t1;
        logic        last;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic s, input logic [5:0] ty, input logic [95:0] ln,
                                input logic [63:0] t0, input logic [63:0] t1, input logic l);
        vec_t v;
        v.is_start = s; v.typ = ty; v.len = ln; v.t0 = t0; v.t1 = t1; v.last = l;
        return v;
    endfunction

    function automatic logic [63:0] exp_t2(input logic [63:0] a, input logic [63:0] b);
`ifdef TWEAK_T2_EN
        return a ^ b;
`else
        return 64'h0 & (a ^ b);
`endif
    endfunction

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_tw(input string tag, input logic [191:0] tw, input logic v,
                            input logic l, input logic [63:0] t0, input logic [63:0] t1,
                            input logic el);
        chk({tag, " valid"}, {191'h0, v}, 192'h1);
        chk({tag, " T0"}, {128'h0, tw[63:0]}, {128'h0, t0});
        chk({tag, " T1"}, {128'h0, tw[127:64]}, {128'h0, t1});
        chk({tag, " T2"}, {128'h0, tw[191:128]}, {128'h0, exp_t2(t0, t1)});
        chk({tag, " last"}, {191'h0, l}, {191'h0, el});
        $display("%s: T0=%h T1=%h T2=%h last=%0d", tag, tw[63:0], tw[127:64], tw[191:128], l);
    endtask

    task automatic main_start(input logic [5:0] ty, input logic [95:0] ln);
        start = 1'b1; typ = ty; len = ln;
        @(negedge clk);
        start = 1'b0; typ = 6'h0; len = 96'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; typ = 6'h0; len = 96'h0; ready = 1'b0;
        s_start = 1'b0; s_typ = 6'h0; s_len = 8'h0; s_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("reset tweak", tweak, 192'h0);
        chk("reset valid", {191'h0, valid}, 192'h0);
        chk("reset busy",  {191'h0, busy},  192'h0);
        chk("reset last",  {191'h0, last},  192'h0);
        chk("reset done",  {191'h0, done},  192'h0);
        chk("reset s_valid", {191'h0, s_valid}, 192'h0);
        $display("reset: tweak=%h valid=%0d busy=%0d", tweak, valid, busy);
        rst_n = 1'b1; ready = 1'b1;
        @(negedge clk);

        // Full-throughput sequences with ready held high
        vecs[0]  = mk(1, TYPE_MSG, 96'd64,  64'h40, 64'hF000000000000000, 1);
        vecs[1]  = mk(1, TYPE_OUT, 96'd8,   64'h8,  64'hFF00000000000000, 1);
        vecs[2]  = mk(1, TYPE_MSG, 96'd130, 64'd64,  64'h7000000000000000, 0);
        vecs[3]  = mk(0, TYPE_MSG, 96'd130, 64'd128, 64'h3000000000000000, 0);
        vecs[4]  = mk(0, TYPE_MSG, 96'd130, 64'd130, 64'hB000000000000000, 1);
        vecs[5]  = mk(1, TYPE_MSG, 96'd0,   64'h0,  64'hF000000000000000, 1);
        vecs[6]  = mk(1, TYPE_CFG, 96'd32,  64'd32, 64'hC400000000000000, 1);
        vecs[7]  = mk(1, TYPE_KEY, 96'd192, 64'd64,  64'h4000000000000000, 0);
        vecs[8]  = mk(0, TYPE_KEY, 96'd192, 64'd128, 64'h0000000000000000, 0);
        vecs[9]  = mk(0, TYPE_KEY, 96'd192, 64'd192, 64'h8000000000000000, 1);
        vecs[10] = mk(1, TYPE_MSG, 96'd65,  64'd64,  64'h7000000000000000, 0);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].is_start) main_start(vecs[i].typ, vecs[i].len);
            check_tw($sformatf("vec%0d", i), tweak, valid, last, vecs[i].t0, vecs[i].t1,
                     vecs[i].last);
            @(negedge clk);
            if (vecs[i].last) begin
                chk($sformatf("vec%0d done", i),  {191'h0, done},  192'h1);
                chk($sformatf("vec%0d idle", i),  {190'h0, valid, busy}, 192'h0);
                @(negedge clk);
                chk($sformatf("vec%0d done pulse", i), {191'h0, done}, 192'h0);
            end
        end
        // vec10 left mid-sequence: its final block follows
        check_tw("vec10b", tweak, valid, last, 64'd65, 64'hB000000000000000, 1'b1);
        @(negedge clk);
        chk("vec10 done", {191'h0, done}, 192'h1);
        @(negedge clk);

        // start_i ignored while busy, including during the final handshake
        ready = 1'b0;
        main_start(TYPE_MSG, 96'd0);
        start = 1'b1; typ = TYPE_OUT; len = 96'd200;
        @(negedge clk);
        check_tw("busy hold", tweak, valid, last, 64'h0, 64'hF000000000000000, 1'b1);
        ready = 1'b1;
        @(negedge clk);
        chk("busy done", {191'h0, done}, 192'h1);
        chk("busy final start ignored", {190'h0, valid, busy}, 192'h0);
        start = 1'b0; typ = 6'h0; len = 96'h0;
        @(negedge clk);
        chk("busy still idle", {190'h0, valid, busy}, 192'h0);

        // Backpressure on block 2 of a 130-byte message
        main_start(TYPE_MSG, 96'd130);
        check_tw("bp blk1", tweak, valid, last, 64'd64, 64'h7000000000000000, 1'b0);
        @(negedge clk);
        check_tw("bp blk2", tweak, valid, last, 64'd128, 64'h3000000000000000, 1'b0);
        ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_tw($sformatf("bp hold%0d", k), tweak, valid, last, 64'd128,
                     64'h3000000000000000, 1'b0);
        end
        ready = 1'b1;
        @(negedge clk);
        check_tw("bp blk3", tweak, valid, last, 64'd130, 64'hB000000000000000, 1'b1);
        @(negedge clk);
        chk("bp done", {191'h0, done}, 192'h1);
        @(negedge clk);

        // Reset after the first handshake of a 3-block run
        main_start(TYPE_MSG, 96'd130);
        check_tw("rst blk1", tweak, valid, last, 64'd64, 64'h7000000000000000, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst tweak", tweak, 192'h0);
        chk("rst state", {189'h0, valid, busy, done}, 192'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst no done", {189'h0, valid, busy, done}, 192'h0);

        // Huge length on the 96-bit position: early blocks not final
        main_start(TYPE_MSG, 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFF6);
        check_tw("huge blk1", tweak, valid, last, 64'd64, 64'h7000000000000000, 1'b0);
        @(negedge clk);
        check_tw("huge blk2", tweak, valid, last, 64'd128, 64'h3000000000000000, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("huge reset", {190'h0, valid, busy}, 192'h0);

        // Narrow position: 192 + 64 would wrap in 8 bits, must saturate to 250
        s_ready = 1'b1;
        s_start = 1'b1; s_typ = TYPE_MSG; s_len = 8'd250;
        @(negedge clk);
        s_start = 1'b0; s_typ = 6'h0; s_len = 8'h0;
        check_tw("sat blk1", s_tweak, s_valid, s_last, 64'd64,  64'h7000000000000000, 1'b0);
        @(negedge clk);
        check_tw("sat blk2", s_tweak, s_valid, s_last, 64'd128, 64'h3000000000000000, 1'b0);
        @(negedge clk);
        check_tw("sat blk3", s_tweak, s_valid, s_last, 64'd192, 64'h3000000000000000, 1'b0);
        @(negedge clk);
        check_tw("sat blk4", s_tweak, s_valid, s_last, 64'd250, 64'hB000000000000000, 1'b1);
        @(negedge clk);
        chk("sat done", {191'h0, s_done}, 192'h1);
        chk("sat idle", {190'h0, s_valid, s_busy}, 192'h0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
